// File: rtl/bus_arbiter_rx_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and constants for the two-driver bus arbiter / reader.
//   arb_state_e : arbiter FSM states
//   SRC_D1/D2   : source tag stored with every received beat
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2,
        TURN = 2'd3
    } arb_state_e;

    localparam logic SRC_D1 = 1'b0;
    localparam logic SRC_D2 = 1'b1;

endpackage

// File: rtl/bus_arbiter_rx_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (control state only)
//   push       : write push_data this cycle (ignored when full)
//   push_data  : WIDTH-bit entry to write
//   pop        : drop the head entry this cycle (ignored when empty)
//   head_data  : current head entry, zero while empty
//   count      : number of stored entries, 0..DEPTH
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // Space is judged on the count before this cycle's pop: no full bypass.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                count <= count + CNT_ONE;
            else if (do_pop && !do_push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_arbiter_rx.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rx
// Owns the enables of two tri-state drivers on a shared bus, arbitrates
// round-robin with bounded hold, inserts one dead turnaround cycle between
// owners, and captures every granted beat (tagged with its source) into a
// FIFO presented downstream as a valid/ready stream.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req1, req2      : driver x has data on offer this cycle
//   ena1, ena2      : driver enables (never both high)
//   bus_in          : shared bus as seen by the reader
//   rx_data, rx_src : head-of-FIFO data and source (0 = driver 1)
//   rx_valid        : FIFO not empty
//   rx_ready        : downstream accepts the head this cycle
//   full            : FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module bus_arbiter_rx
    import bus_arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic             req2,
    output logic             ena1,
    output logic             ena2,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_src,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             full
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam int BW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [BW-1:0] HOLD_LAST = BW'(HOLD_MAX - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    arb_state_e       state;
    logic             last_src;
    logic [BW-1:0]    beats;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             beat;
    logic [WIDTH:0]   push_data;
    logic [WIDTH:0]   head_data;

    // Enables come from registered state; a full FIFO stalls the owner.
    assign ena1 = (state == GNT1) & req1 & (fifo_count < DEPTH_C);
    assign ena2 = (state == GNT2) & req2 & (fifo_count < DEPTH_C);

    assign beat      = ena1 | ena2;
    assign push_data = {(ena2 ? SRC_D2 : SRC_D1), bus_in};

    assign rx_valid = ~fifo_empty;
    assign rx_src   = head_data[WIDTH];
    assign rx_data  = head_data[WIDTH-1:0];

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat),
        .push_data (push_data),
        .pop       (rx_ready),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_src <= SRC_D2;  // so driver 1 wins the first tie
            beats    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req1 && req2)
                        state <= (last_src == SRC_D1) ? GNT2 : GNT1;
                    else if (req1)
                        state <= GNT1;
                    else if (req2)
                        state <= GNT2;
                end
                GNT1: begin
                    if (!req1 || (ena1 && beats == HOLD_LAST)) begin
                        state    <= TURN;
                        last_src <= SRC_D1;
                        beats    <= '0;
                    end else if (ena1) begin
                        beats <= beats + BEAT_ONE;
                    end
                end
                GNT2: begin
                    if (!req2 || (ena2 && beats == HOLD_LAST)) begin
                        state    <= TURN;
                        last_src <= SRC_D2;
                        beats    <= '0;
                    end else if (ena2) begin
                        beats <= beats + BEAT_ONE;
                    end
                end
                TURN: begin
                    // Dead cycle done: prefer the requester that did not just own the bus.
                    if (last_src == SRC_D1) begin
                        if (req2)      state <= GNT2;
                        else if (req1) state <= GNT1;
                        else           state <= IDLE;
                    end else begin
                        if (req1)      state <= GNT1;
                        else if (req2) state <= GNT2;
                        else           state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
